// File: rtl/pulp_level_shifter_in_sync.sv
// pulp_level_shifter_in_sync
// Brings a level-shifted, asynchronous input into the clk_i domain:
// synchroniser chain, debounce filter, clean level plus rise/fall pulses.
// The output is frozen while the source domain is isolated.
// Optional feature macro: LS_IN_SYNC_STICKY_EN adds sticky rise/fall flags
// cleared by clr_i; without it the sticky outputs are tied low.
module pulp_level_shifter_in_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic iso_en_i,
  input  logic in_i,
  input  logic clr_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_sticky_o,
  output logic fall_sticky_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   commit;

  // ---- stage 0: synchroniser chain, runs every cycle even when isolated
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  // ---- stage 1: debounce next-state, counter and edge pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;
    if (iso_en_i) begin
      // isolation freezes the level and discards any partial count
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s != out_q) begin
            if (CNT_ONE == CNT_DONE) begin
              commit = 1'b1;
            end else begin
              state_d = COUNT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        COUNT: begin
          if (s == out_q) begin
            // glitch rejected: sample returned to the current level
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (commit) begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = s;
        rise_d  = s;
        fall_d  = ~s;
      end
    end
  end

  // Debounce state, level and pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef LS_IN_SYNC_STICKY_EN
  logic rise_sticky_q, fall_sticky_q;

  // ---- stage 2: sticky flags; a pulse on the outputs beats a coincident clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_sticky_q <= 1'b0;
      fall_sticky_q <= 1'b0;
    end else begin
      rise_sticky_q <= rise_q | (rise_sticky_q & ~clr_i);
      fall_sticky_q <= fall_q | (fall_sticky_q & ~clr_i);
    end
  end

  assign rise_sticky_o = rise_sticky_q;
  assign fall_sticky_o = fall_sticky_q;
`else
  logic unused_clr;
  assign unused_clr    = clr_i;
  assign rise_sticky_o = 1'b0;
  assign fall_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_pulp_level_shifter_in_sync.sv
// Testbench for pulp_level_shifter_in_sync (default parameters).
// A window-based reference model recomputes the expected outputs from the
// recorded input history at every clock edge; directed steps add latency checks.
module tb_pulp_level_shifter_in_sync;

  localparam int   SYNC = 2;
  localparam int   DEB  = 4;
  localparam logic RV   = 1'b0;
  localparam int   NMAX = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iso = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;
  logic out, rise, fall, rise_st, fall_st;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  pulp_level_shifter_in_sync #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_VALUE(RV)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .iso_en_i(iso),
    .in_i(din),
    .clr_i(clr),
    .out_o(out),
    .rise_o(rise),
    .fall_o(fall),
    .rise_sticky_o(rise_st),
    .fall_sticky_o(fall_st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs == exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: history of inputs per edge, outputs from windows over it.
  logic in_h [NMAX];
  logic rst_h[NMAX];
  logic iso_h[NMAX];
  logic s_h  [NMAX];
  int   n = 0;
  logic out_m = RV, rise_m = 1'b0, fall_m = 1'b0, rs_m = 1'b0, fs_m = 1'b0;

  always @(posedge clk) begin
    bit s_rst, ok;
    if (n < NMAX) begin
      in_h[n]  = din;
      rst_h[n] = rst;
      iso_h[n] = iso;
      // value the filter sees at edge n: input from SYNC edges ago, unless a
      // reset landed in between
      s_rst = 1'b0;
      for (int j = 1; j <= SYNC; j++)
        if (n - j < 0 || rst_h[n-j]) s_rst = 1'b1;
      if (s_rst) s_h[n] = RV;
      else       s_h[n] = in_h[n-SYNC];
      if (rst) begin
        out_m = RV; rise_m = 1'b0; fall_m = 1'b0; rs_m = 1'b0; fs_m = 1'b0;
      end else begin
        rs_m = rise_m | (rs_m & ~clr);
        fs_m = fall_m | (fs_m & ~clr);
        // level changes only when the last DEB filter samples all differ from
        // it with no reset or isolation among those edges
        ok = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (n - j < 0 || rst_h[n-j] || iso_h[n-j] || s_h[n-j] == out_m) ok = 1'b0;
        rise_m = ok && s_h[n];
        fall_m = ok && !s_h[n];
        if (ok) out_m = s_h[n];
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out", out, out_m);
      check("model_rise", rise, rise_m);
      check("model_fall", fall, fall_m);
`ifdef LS_IN_SYNC_STICKY_EN
      check("model_rise_sticky", rise_st, rs_m);
      check("model_fall_sticky", fall_st, fs_m);
`else
      check("model_rise_sticky", rise_st, 1'b0);
      check("model_fall_sticky", fall_st, 1'b0);
`endif
    end
  end

  initial begin
    int lat;
    int pulses;
    logic [10:0] dip;

    // reset held two cycles with input high
    rst = 1'b1; din = 1'b1;
    tick();
    check("reset_out", out, RV);
    check("reset_rise", rise, 1'b0);
    chk_en = 1'b1;
    tick();
    check("reset_out_2", out, RV);
    check("reset_rise_2", rise, 1'b0);
    rst = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin tick(); if (out === 1'b1) begin lat = k; break; end end
    check_int("reset_release_latency", lat, 5);
    check("reset_release_rise", rise, 1'b1);
    tick();
    check("reset_release_rise_single", rise, 1'b0);

    // clean falling edge
    din = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin tick(); if (fall === 1'b1) begin lat = k; break; end end
    check_int("clean_fall_latency", lat, 5);
    check("clean_fall_out", out, 1'b0);

    // clean rising edge
    din = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin tick(); if (rise === 1'b1) begin lat = k; break; end end
    check_int("clean_rise_latency", lat, 5);
    din = 1'b0;
    repeat (8) tick();
    check("settle_low", out, 1'b0);

    // glitch: three cycles high
    pulses = 0;
    din = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 3) din = 1'b0;
      tick();
      if (rise === 1'b1 || fall === 1'b1) pulses++;
    end
    check_int("glitch_pulses", pulses, 0);
    check("glitch_out", out, 1'b0);

    // 1-cycle dip inside a high window restarts the count
    dip = 11'b000_1110111;
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      din = dip[k];
      tick();
      if (rise === 1'b1 || fall === 1'b1) pulses++;
    end
    din = 1'b0;
    repeat (4) tick();
    check_int("dip_pulses", pulses, 0);
    check("dip_out", out, 1'b0);

    // isolation freezes the level
    din = 1'b1;
    repeat (8) tick();
    check("iso_pre_out", out, 1'b1);
    iso = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      din = 1'($urandom_range(0, 1));
      tick();
      if (rise === 1'b1 || fall === 1'b1 || out !== 1'b1) pulses++;
    end
    check_int("iso_frozen", pulses, 0);
    din = 1'b0;
    repeat (3) tick();
    iso = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin tick(); if (out === 1'b0) begin lat = k; break; end end
    check_int("iso_release_latency", lat, 3);

    // isolation asserted on the edge the count would complete
    din = 1'b1;
    repeat (5) tick();
    iso = 1'b1;
    tick();
    check("iso_wins_out", out, 1'b0);
    check("iso_wins_rise", rise, 1'b0);
    iso = 1'b0;
    din = 1'b0;
    repeat (6) tick();

    // reset in the middle of a rising debounce
    din = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_out", out, 1'b0);
    lat = -1;
    for (int k = 0; k < 20; k++) begin tick(); if (out === 1'b1) begin lat = k; break; end end
    check_int("midreset_restart_latency", lat, 5);
    din = 1'b0;
    repeat (8) tick();

`ifdef LS_IN_SYNC_STICKY_EN
    // clear coinciding with the rise pulse loses; a later clear wins
    din = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin tick(); if (rise === 1'b1) begin lat = k; break; end end
    check_int("sticky_rise_seen", lat, 5);
    clr = 1'b1;
    tick();
    check("sticky_set_beats_clr", rise_st, 1'b1);
    tick();
    check("sticky_cleared", rise_st, 1'b0);
    clr = 1'b0;
    din = 1'b0;
    repeat (8) tick();
    check("sticky_fall_set", fall_st, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sticky_fall_cleared", fall_st, 1'b0);
`else
    // sticky outputs stay low whatever clr_i and the input do
    for (int k = 0; k < 16; k++) begin
      clr = 1'(k % 2);
      din = (k >= 2 && k < 10) ? 1'b1 : 1'b0;
      tick();
      check("sticky_off_rise", rise_st, 1'b0);
      check("sticky_off_fall", fall_st, 1'b0);
    end
    clr = 1'b0;
`endif

    // randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) din = ~din;
      if ($urandom_range(0, 24) == 0) iso = ~iso;
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; iso = 1'b0; clr = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
